tag_unit: RTL

- Response/tag register stage that sits directly downstream of the CAPP cell array and closes the loop back into it.
- Consumes the array's per-word match_lines and holds the tag vector that drives the array's tags input.
- Supports set/clear, search-load, search-and-narrow, select-first, and a multi-cycle STEP that presents responders one at a time to the controller for read/write.
- Provides some/none flags and an optional responder count.

---
 rtl/tag_unit_pkg.sv | 21 ++
 rtl/first_responder.sv | 15 +
 rtl/tag_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tag_unit_pkg.sv
// Shared definitions for the tag_unit response/tag register stage:
// operation codes, controller state type and the default word count.
package tag_unit_pkg;

    localparam int DEFAULT_WORDS = 100;

    localparam logic [2:0] OP_NOP          = 3'd0;
    localparam logic [2:0] OP_SET_ALL      = 3'd1;
    localparam logic [2:0] OP_CLEAR_ALL    = 3'd2;
    localparam logic [2:0] OP_SEARCH_LOAD  = 3'd3;
    localparam logic [2:0] OP_SEARCH_AND   = 3'd4;
    localparam logic [2:0] OP_SELECT_FIRST = 3'd5;
    localparam logic [2:0] OP_STEP         = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/first_responder.sv
// Combinational isolate of the lowest-index set bit of a word vector;
// the result is one-hot, or zero when no bit is set.
module first_responder
    import tag_unit_pkg::*;
#(
    parameter int WORDS = DEFAULT_WORDS
) (
    input  logic [WORDS-1:0] vec,
    output logic [WORDS-1:0] first
);

    // Two's complement flips every bit above the lowest one, so the AND keeps only it.
    assign first = vec & (-vec);

endmodule

// File: rtl/tag_unit.sv
// Tag register stage closing the loop from match_lines back into the cell array.
// Define TAG_COUNT_EN to build the registered responder popcount; otherwise count is 0.
module tag_unit
    import tag_unit_pkg::*;
#(
    parameter int WORDS = DEFAULT_WORDS,
    parameter int CNT_W = 7
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WORDS-1:0] match_lines,
    input  logic [2:0]       op,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [WORDS-1:0] tags,
    output logic             some,
    output logic             none,
    output logic [CNT_W-1:0] count,
    output logic             iter_valid,
    input  logic             iter_ack,
    output logic             iter_done
);

    state_t           state;
    logic [WORDS-1:0] save;
    logic [WORDS-1:0] pending;
    logic [WORDS-1:0] first_tags;
    logic [WORDS-1:0] remaining;
    logic [WORDS-1:0] first_rem;
    logic [WORDS-1:0] idle_tags;
    logic             flag_upd;

    assign op_ready  = (state == IDLE);
    assign remaining = pending & ~tags;
    // Flags track single-cycle ops only; a STEP leaves them at their pre-STEP values.
    assign flag_upd  = (state == IDLE) && !(op_valid && op == OP_STEP);

    first_responder #(.WORDS(WORDS)) u_first_tags (
        .vec   (tags),
        .first (first_tags)
    );

    first_responder #(.WORDS(WORDS)) u_first_rem (
        .vec   (remaining),
        .first (first_rem)
    );

    // NOTE: idle_tags gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        idle_tags = tags;
        if (op_valid) begin
            case (op)
                OP_NOP:          idle_tags = tags;
                OP_SET_ALL:      idle_tags = '1;
                OP_CLEAR_ALL:    idle_tags = '0;
                OP_SEARCH_LOAD:  idle_tags = ~match_lines;
                OP_SEARCH_AND:   idle_tags = tags & ~match_lines;
                OP_SELECT_FIRST: idle_tags = first_tags;
                default:         idle_tags = tags;
            endcase
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            tags       <= '0;
            save       <= '0;
            pending    <= '0;
            some       <= 1'b0;
            none       <= 1'b1;
            iter_valid <= 1'b0;
            iter_done  <= 1'b0;
        end else begin
            iter_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid && op == OP_STEP) begin
                        save    <= tags;
                        pending <= tags;
                        if (tags == '0) begin
                            iter_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            tags       <= first_tags;
                            iter_valid <= 1'b1;
                            state      <= ITER;
                        end
                    end else if (flag_upd) begin
                        tags <= idle_tags;
                        some <= |idle_tags;
                        none <= ~|idle_tags;
                    end
                end
                ITER: begin
                    if (iter_ack) begin
                        pending <= remaining;
                        if (remaining != '0) begin
                            tags <= first_rem;
                        end else begin
                            tags       <= save;
                            iter_valid <= 1'b0;
                            iter_done  <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TAG_COUNT_EN
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < WORDS; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(idle_tags[i]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (flag_upd) begin
            count <= cnt_nxt;
        end
    end
`else
    assign count = '0;
`endif

endmodule
